// File: rtl/odmb_trig_sequencer.sv
// Trigger playback sequencer for ODMB standalone/test modes.
// A small table of timestamped trigger entries is loaded while idle.
// After start, each entry is emitted as a one-clock pulse when the local
// timestamp counter reaches the entry timestamp. Entries whose timestamp
// has already passed are skipped and flagged in the sticky err_late.
// The table is read through a one-entry lookahead (cur_r holds the entry
// under compare, mem_q_r already holds the following one), so consecutive
// timestamps fire on consecutive enabled cycles.
module odmb_trig_sequencer #(
   parameter int DEPTH_LOG2 = 6,
   parameter int TS_WIDTH   = 32,
   parameter int LCT_WIDTH  = 8
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              wr_en,
   input  logic [DEPTH_LOG2-1:0]             wr_addr,
   input  logic [TS_WIDTH+3+LCT_WIDTH-1:0]   wr_data,
   input  logic [DEPTH_LOG2:0]               n_entries,
   input  logic                              start,
   input  logic                              stop,
   input  logic                              loop_en,
   input  logic                              en,
   output logic                              l1a,
   output logic                              alct_dav,
   output logic                              tmb_dav,
   output logic [LCT_WIDTH-1:0]              lct,
   output logic [TS_WIDTH-1:0]               ts_cnt,
   output logic                              busy,
   output logic                              done,
   output logic                              err_late
);

   localparam int ENTRY_W = TS_WIDTH + 3 + LCT_WIDTH;
   localparam int DEPTH   = 1 << DEPTH_LOG2;
   localparam int PTR_W   = DEPTH_LOG2 + 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ARM  = 2'd1,
      RUN  = 2'd2
   } state_t;

   state_t state_r, state_next_s;

   logic [ENTRY_W-1:0]    mem_r [DEPTH];
   logic [ENTRY_W-1:0]    mem_q_r;
   logic [ENTRY_W-1:0]    cur_r;
   logic [PTR_W-1:0]      ptr_r;
   logic [PTR_W-1:0]      n_r;
   logic [PTR_W-1:0]      n_clamp_s;
   logic [PTR_W-1:0]      n_last_s;
   logic [PTR_W-1:0]      ptr_p1_s;
   logic [PTR_W-1:0]      ptr_p2_s;
   logic [DEPTH_LOG2-1:0] rd_addr_s;
   logic                  arm_cnt_r;
   logic [TS_WIDTH-1:0]   cur_ts_s;
   logic [TS_WIDTH-1:0]   ts_cnt_r;
   logic                  start_ok_s;
   logic                  fire_s;
   logic                  late_s;
   logic                  consume_s;
   logic                  last_s;
   logic                  l1a_r, alct_dav_r, tmb_dav_r;
   logic [LCT_WIDTH-1:0]  lct_r;
   logic                  busy_r, done_r, err_late_r;

   assign cur_ts_s = cur_r[ENTRY_W-1 -: TS_WIDTH];
   assign ptr_p1_s = ptr_r + PTR_W'(1);
   assign ptr_p2_s = ptr_r + PTR_W'(2);
   assign n_last_s = n_r - PTR_W'(1);

   // Clamp the requested entry count to the table depth.
   always_comb begin
      n_clamp_s = n_entries;
      if (n_entries > PTR_W'(DEPTH)) begin
         n_clamp_s = PTR_W'(DEPTH);
      end else begin
         n_clamp_s = n_entries;
      end
   end

   // Next-state logic, compare decisions and table read address.
   always_comb begin
      state_next_s = state_r;
      rd_addr_s    = {DEPTH_LOG2{1'b0}};
      fire_s       = 1'b0;
      late_s       = 1'b0;
      start_ok_s   = (state_r == IDLE) && start && !stop &&
                     (n_entries != {PTR_W{1'b0}});
      if ((state_r == RUN) && en && !stop) begin
         fire_s = (cur_ts_s == ts_cnt_r);
         late_s = (ts_cnt_r > cur_ts_s);
      end else begin
         fire_s = 1'b0;
         late_s = 1'b0;
      end
      consume_s = fire_s | late_s;
      last_s    = consume_s && (ptr_r == n_last_s);

      case (state_r)
         IDLE: begin
            if (start_ok_s) begin
               state_next_s = ARM;
            end else begin
               state_next_s = IDLE;
            end
         end
         ARM: begin
            // first ARM clock fetches entry 0, second fetches entry 1
            rd_addr_s = arm_cnt_r ? DEPTH_LOG2'(1) : DEPTH_LOG2'(0);
            if (stop) begin
               state_next_s = IDLE;
            end else if (arm_cnt_r) begin
               state_next_s = RUN;
            end else begin
               state_next_s = ARM;
            end
         end
         RUN: begin
            // keep mem_q_r one entry ahead of cur_r
            rd_addr_s = consume_s ? ptr_p2_s[DEPTH_LOG2-1:0]
                                  : ptr_p1_s[DEPTH_LOG2-1:0];
            if (stop) begin
               state_next_s = IDLE;
            end else if (last_s) begin
               state_next_s = loop_en ? ARM : IDLE;
            end else begin
               state_next_s = RUN;
            end
         end
         default: begin
            state_next_s = IDLE;
         end
      endcase
   end

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Trigger table: writes only while idle, one-cycle registered read.
   always_ff @(posedge clk) begin
      if (wr_en && (state_r == IDLE)) begin
         mem_r[wr_addr] <= wr_data;
      end
      mem_q_r <= mem_r[rd_addr_s];
   end

   // Playback datapath: counter, pointer, lookahead entry and pulse outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ts_cnt_r   <= {TS_WIDTH{1'b0}};
         err_late_r <= 1'b0;
         ptr_r      <= {PTR_W{1'b0}};
         n_r        <= {PTR_W{1'b0}};
         arm_cnt_r  <= 1'b0;
         cur_r      <= {ENTRY_W{1'b0}};
         l1a_r      <= 1'b0;
         alct_dav_r <= 1'b0;
         tmb_dav_r  <= 1'b0;
         lct_r      <= {LCT_WIDTH{1'b0}};
         busy_r     <= 1'b0;
         done_r     <= 1'b0;
      end else begin
         l1a_r      <= 1'b0;
         alct_dav_r <= 1'b0;
         tmb_dav_r  <= 1'b0;
         lct_r      <= {LCT_WIDTH{1'b0}};
         done_r     <= 1'b0;
         busy_r     <= (state_next_s != IDLE);
         case (state_r)
            IDLE: begin
               if (start_ok_s) begin
                  ts_cnt_r   <= {TS_WIDTH{1'b0}};
                  err_late_r <= 1'b0;
                  ptr_r      <= {PTR_W{1'b0}};
                  n_r        <= n_clamp_s;
                  arm_cnt_r  <= 1'b0;
               end
            end
            ARM: begin
               if (!stop) begin
                  arm_cnt_r <= ~arm_cnt_r;
                  if (arm_cnt_r) begin
                     cur_r <= mem_q_r;
                  end
               end
            end
            RUN: begin
               if (!stop && en) begin
                  ts_cnt_r <= ts_cnt_r + TS_WIDTH'(1);
                  if (fire_s) begin
                     l1a_r      <= cur_r[LCT_WIDTH+2];
                     alct_dav_r <= cur_r[LCT_WIDTH+1];
                     tmb_dav_r  <= cur_r[LCT_WIDTH];
                     lct_r      <= cur_r[LCT_WIDTH-1:0];
                  end
                  if (late_s) begin
                     err_late_r <= 1'b1;
                  end
                  if (consume_s) begin
                     if (last_s) begin
                        if (loop_en) begin
                           // restart: clear overrides the increment above
                           ptr_r     <= {PTR_W{1'b0}};
                           ts_cnt_r  <= {TS_WIDTH{1'b0}};
                           arm_cnt_r <= 1'b0;
                        end else begin
                           done_r <= 1'b1;
                        end
                     end else begin
                        ptr_r <= ptr_p1_s;
                        cur_r <= mem_q_r;
                     end
                  end
               end
            end
            default: begin
               ptr_r <= {PTR_W{1'b0}};
            end
         endcase
      end
   end

   assign l1a      = l1a_r;
   assign alct_dav = alct_dav_r;
   assign tmb_dav  = tmb_dav_r;
   assign lct      = lct_r;
   assign ts_cnt   = ts_cnt_r;
   assign busy     = busy_r;
   assign done     = done_r;
   assign err_late = err_late_r;

endmodule

// File: doc/odmb_trig_sequencer.md
Name: odmb_trig_sequencer

Overview:
Synthesizable trigger playback sequencer for ODMB standalone/test modes. Holds a small table of timestamped trigger entries (L1A, ALCT_DAV, TMB_DAV, 8-bit LCT) loaded by the slow-control path. When started, it plays each entry out as a one-clock pulse when a local timestamp counter reaches the entry's timestamp. It drives the same trigger inputs that the CFEB/ALCT/TMB readout logic normally receives from the backplane.

Parameters:
DEPTH_LOG2, 6, log2 of table depth (64 entries)
TS_WIDTH, 32, timestamp/counter width
LCT_WIDTH, 8, LCT bit vector width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous reset, active-high
wr_en  in  1  table write strobe
wr_addr  in  DEPTH_LOG2  table write address
wr_data  in  TS_WIDTH+3+LCT_WIDTH  {ts, l1a, alct_dav, tmb_dav, lct}, ts in MSBs
n_entries  in  DEPTH_LOG2+1  number of entries to play
start  in  1  start playback (pulse)
stop  in  1  abort playback (pulse)
loop_en  in  1  replay table continuously
en  in  1  timestamp tick enable
l1a  out  1  L1A pulse
alct_dav  out  1  ALCT data-available pulse
tmb_dav  out  1  TMB data-available pulse
lct  out  LCT_WIDTH  LCT vector, valid with pulse
ts_cnt  out  TS_WIDTH  current timestamp
busy  out  1  playback active (ARM or RUN)
done  out  1  one-clock pulse at end of non-looped playback
err_late  out  1  sticky: entry skipped because its timestamp was already passed

Behaviour:
- Reset: state IDLE; l1a, alct_dav, tmb_dav, lct, ts_cnt, busy, done, err_late = 0; read pointer = 0. Table contents are not reset.
- Table: 2^DEPTH_LOG2 entries, synchronous write, one-cycle synchronous read.
- Writes are accepted only in IDLE. Writes while busy are ignored.
- States:
  - IDLE: start with n_entries != 0 clears ts_cnt and err_late, sets pointer = 0, enters ARM.
  - start with n_entries == 0 is ignored.
  - n_entries > 2^DEPTH_LOG2 is clamped to 2^DEPTH_LOG2.
- ARM: exactly 2 clocks for the table prefetch. ts_cnt holds; en is ignored. Then enter RUN.
- RUN, on each clock with en = 1:
  - Compare the current entry's ts to ts_cnt.
  - Equal: fire. Trigger outputs are registered and equal the entry fields on the next clock, for exactly one clock. Advance the pointer.
  - ts_cnt > entry ts (late): no pulse, set err_late, advance the pointer.
  - ts_cnt < entry ts: wait.
  - ts_cnt increments on the same edge.
- RUN with en = 0: ts_cnt holds; no compare; outputs 0.
- Back-to-back entries (ts, ts+1) must fire on consecutive en cycles. The implementation provides a one-entry lookahead so the compare never stalls.
- Equal or decreasing timestamps in consecutive entries: the later entry is late (skipped, err_late set).
- End of table, after entry n_entries-1 is consumed (fired or skipped):
  - loop_en = 0: pulse done for one clock (coincident with the last trigger pulse, if any), busy drops, enter IDLE.
  - loop_en = 1: pointer = 0, ts_cnt cleared, enter ARM. done is not pulsed.
  - loop_en is sampled at the consume edge.
- Trigger outputs are 0 in every cycle other than the single pulse cycle. In the pulse cycle, unset fields are output as stored (an entry may carry lct only).
- ts_cnt wraps from all-ones to 0 and continues.
- stop in any state: next edge → IDLE. ts_cnt holds its value; outputs 0; no done; err_late keeps its value.
- start and stop asserted together: stop wins. start while busy is ignored.
- rst asserted mid-playback: immediate return to the reset values.

Test Plan:
- Load 3 entries {ts=5,l1a}, {ts=6,alct_dav+tmb_dav,lct=0x81}, {ts=20,l1a+lct=0x03}; n_entries=3; start; en=1 continuous → pulses while ts_cnt = 6, 7, 21 (one clock each, correct fields); done coincides with the last pulse; busy low afterwards; err_late = 0.
- Same table with en toggling 1/0 every clock → pulses occur only after the 6th, 7th and 21st en cycles; spacing in clocks doubles; no pulse when en = 0.
- Entries ts = 10, 10, 4 → first fires at ts 10; second and third are skipped; err_late = 1; done pulses; only one l1a pulse in total.
- loop_en = 1 with one entry ts=2 → a pulse every 2 (ARM) + 3 clocks with en = 1, repeating; no done; stop → next edge idle, no further pulses.
- stop and start in the same clock while running → IDLE. Write during RUN → table unchanged (verified by a second playback). rst mid-RUN → all outputs 0 immediately.
- n_entries = 0 start → ignored, busy stays 0. n_entries = 100 → 64 entries played.
